// File: rtl/ps2_pkg.sv
// Shared types and 25 MHz timing defaults for the PS/2 host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRelease,
    StSend,
    StAck,
    StWaitIdle
  } ps2_state_e;

  // data[7:0] + parity + stop
  localparam int unsigned PS2_FRAME_BITS     = 10;

  localparam int unsigned INHIBIT_CYCLES_DEF = 3000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 375000;
  localparam int unsigned FILTER_CYCLES_DEF  = 8;

endpackage

// File: rtl/ps2_line_sync.sv
// 2-flop synchronizer for one PS/2 line with a falling-edge pulse.
// Define PS2_TX_FILTER_EN to add a stability filter after the synchronizer.
module ps2_line_sync
`ifdef PS2_TX_FILTER_EN
#(
  parameter int unsigned FILTER_CYCLES = 8
)
`endif
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       level;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_i};
      prev_q <= level;
    end
  end

`ifdef PS2_TX_FILTER_EN
  localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            filt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (sync_q[1] == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CntLast) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  assign level_o = level;
  assign fall_o  = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Define PS2_TX_FILTER_EN to filter both input lines before edge detection.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`ifdef PS2_TX_FILTER_EN
  ,
  parameter int unsigned FILTER_CYCLES  = FILTER_CYCLES_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [InhW-1:0] InhEnd  = InhW'(INHIBIT_CYCLES);
  localparam logic [3:0]      LastBit = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e                state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0]           inh_cnt_q, inh_cnt_d;
  logic [WdW-1:0]            wd_q, wd_d;
  logic                      clk_oe_q, clk_oe_d;
  logic                      data_oe_q, data_oe_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;

  logic clk_level, clk_fall;
  logic data_level, data_fall_unused;

  ps2_line_sync
`ifdef PS2_TX_FILTER_EN
  #(.FILTER_CYCLES(FILTER_CYCLES))
`endif
  u_clk_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .line_i  (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync
`ifdef PS2_TX_FILTER_EN
  #(.FILTER_CYCLES(FILTER_CYCLES))
`endif
  u_data_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .line_i  (ps2_data_in),
    .level_o (data_level),
    .fall_o  (data_fall_unused)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    wd_d      = wd_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        if (inh_cnt_q == InhEnd) begin
          clk_oe_d = 1'b0;
          wd_d     = '0;
          state_d  = StRelease;
        end else if (inh_cnt_q == InhEnd - 1'b1) begin
          data_oe_d = 1'b1;
        end
      end
      StRelease: begin
        bit_cnt_d = '0;
        state_d   = StSend;
      end
      StSend: begin
        // The device samples on its rising edge, so data only moves on a fall.
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[PS2_FRAME_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) state_d = StAck;
        end
      end
      StAck: begin
        if (clk_fall) begin
          if (!data_level) begin
            state_d = StWaitIdle;
          end else begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWaitIdle: begin
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Watchdog overrides any same-cycle completion.
    if (state_q inside {StRelease, StSend, StAck, StWaitIdle}) begin
      if (clk_fall) begin
        wd_d = '0;
      end else if (wd_q == WdLast) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b1;
        state_d   = StIdle;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      wd_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      wd_q      <= wd_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_ready    = (state_q == StIdle);
  assign rx_inhibit  = (state_q != StIdle);
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
